alu_seq: RTL and testbench

- Parametrised, registered successor to the single-cycle datapath ALU.
- Same opcode set and ALUOp pass-through modes, generalised to WIDTH bits.
- Multiply, divide and modulo run as iterative multi-cycle operations, removing the combinational multiplier/divider from the critical path.
- Sits in the EX stage; the control unit issues an operation with `start` and stalls the pipeline while `busy` is high.

---
 rtl/alu_seq.sv | 153 +++++++++++++++
 tb/tb_alu_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered EX-stage ALU: single-cycle logic/arith ops plus iterative shift-add multiply
// and restoring divide/modulo, each taking WIDTH cycles before the DONE cycle.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [5:0]       operation,
    input  logic [1:0]       ALUOp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] aluResult,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q;   // product accumulator / partial remainder
    logic [WIDTH-1:0] opa_q;   // shifting multiplicand / dividend-then-quotient
    logic [WIDTH-1:0] opb_q;   // shifting multiplier / divisor
    logic             mod_q;
    logic             zf_q;
    logic             busy_q, done_q, zero_q;
    logic [WIDTH-1:0] res_q;

    logic [WIDTH-1:0] single_res;
    logic             zero_in, is_mul, is_div;
    logic [WIDTH-1:0] mul_acc_d;
    logic [WIDTH:0]   rem_sh, rem_diff;
    logic [WIDTH-1:0] rem_d, quo_d;

    always_comb begin
        single_res = '0;
        if (ALUOp[0]) begin
            single_res = data2;
        end else begin
            case (operation)
                6'b000000: single_res = data1;
                6'b000001: single_res = data1 + data2;
                6'b000010: single_res = data1 - data2;
                6'b000011: single_res = data1 & data2;
                6'b000100: single_res = data1 | data2;
                6'b000101: single_res = data1 ^ data2;
                6'b000110: single_res = ~data1;
                6'b000111: single_res = data1 << data2;
                6'b001000: single_res = data1 >> data2;
                default:   single_res = '0;
            endcase
        end
        zero_in = ((data1 - data2) == '0) ^ (ALUOp == 2'b10);
        is_mul  = !ALUOp[0] && (operation == 6'b001001);
        is_div  = !ALUOp[0] && (operation == 6'b001010 || operation == 6'b001011);
    end

    always_comb begin
        mul_acc_d = opb_q[0] ? acc_q + opa_q : acc_q;
        // Restoring step: shift next dividend bit into the remainder, keep the
        // difference only if it did not go negative.
        rem_sh    = {acc_q, opa_q[WIDTH-1]};
        rem_diff  = rem_sh - {1'b0, opb_q};
        if (!rem_diff[WIDTH]) begin
            rem_d = rem_diff[WIDTH-1:0];
            quo_d = {opa_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = rem_sh[WIDTH-1:0];
            quo_d = {opa_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            mod_q   <= 1'b0;
            zf_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        zf_q   <= zero_in;
                        mod_q  <= operation[0];
                        cnt_q  <= '0;
                        acc_q  <= '0;
                        opa_q  <= data1;
                        opb_q  <= data2;
                        if (is_mul) begin
                            state_q <= StMul;
                        end else if (is_div) begin
                            state_q <= StDiv;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            res_q   <= single_res;
                            zero_q  <= zero_in;
                        end
                    end
                end
                StMul: begin
                    acc_q <= mul_acc_d;
                    opa_q <= opa_q << 1;
                    opb_q <= opb_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        res_q   <= mul_acc_d;
                        zero_q  <= zf_q;
                    end
                end
                StDiv: begin
                    acc_q <= rem_d;
                    opa_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        res_q   <= mod_q ? rem_d : quo_d;
                        zero_q  <= zf_q;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign aluResult = res_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed plan cases plus random ops checked against an arithmetic model.
module tb_alu_seq;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset, start;
    logic [W-1:0] data1, data2;
    logic [5:0]   operation;
    logic [1:0]   ALUOp;
    logic         busy, done, zero;
    logic [W-1:0] aluResult;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    alu_seq #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .data1     (data1),
        .data2     (data2),
        .operation (operation),
        .ALUOp     (ALUOp),
        .busy      (busy),
        .done      (done),
        .aluResult (aluResult),
        .zero      (zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [5:0] op, input logic [1:0] aop);
        if (aop == 2'b01 || aop == 2'b11) return b;
        case (op)
            6'd0:    return a;
            6'd1:    return a + b;
            6'd2:    return a - b;
            6'd3:    return a & b;
            6'd4:    return a | b;
            6'd5:    return a ^ b;
            6'd6:    return ~a;
            6'd7:    return (b >= W) ? '0 : a << b;
            6'd8:    return (b >= W) ? '0 : a >> b;
            6'd9:    return a * b;
            6'd10:   return (b == 0) ? '1 : a / b;
            6'd11:   return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [5:0] op, input logic [1:0] aop);
        if (aop[0] == 1'b0 && op >= 6'd9 && op <= 6'd11) return W + 1;
        return 1;
    endfunction

    // Issue one op in the current (idle) cycle, follow it to done and one cycle beyond.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] op,
                          input logic [1:0] aop, input bit mid_start, input string tag);
        logic [W-1:0] exp_r;
        logic         exp_z;
        int           exp_l, cyc;
        exp_r = ref_result(a, b, op, aop);
        exp_z = (a == b) ^ (aop == 2'b10);
        exp_l = ref_latency(op, aop);
        data1 = a; data2 = b; operation = op; ALUOp = aop; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        data1 = $urandom; data2 = $urandom; operation = 6'($urandom); ALUOp = 2'($urandom);
        check({tag, "/busy"}, 64'(busy), 64'd1);
        cyc = 1;
        while (!done && cyc < 100) begin
            if (mid_start && cyc == 5) begin
                start = 1'b1; operation = 6'd1; ALUOp = 2'b00;
            end
            @(posedge clock); #1;
            start = 1'b0;
            cyc++;
        end
        check({tag, "/latency"}, 64'(cyc), 64'(exp_l));
        check({tag, "/result"}, 64'(aluResult), 64'(exp_r));
        check({tag, "/zero"}, 64'(zero), 64'(exp_z));
        @(posedge clock); #1;
        check({tag, "/idle"}, {62'd0, busy, done}, 64'd0);
        check({tag, "/hold"}, 64'(aluResult), 64'(exp_r));
    endtask

    initial begin
        int ndone;
        logic [W-1:0] a, b;
        reset = 1'b1; start = 1'b0; data1 = '0; data2 = '0; operation = '0; ALUOp = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("reset/outs", {61'd0, busy, done, zero}, 64'd0);
        check("reset/result", 64'(aluResult), 64'd0);

        run_op(32'd5, 32'd7, 6'd1, 2'b00, 1'b0, "add");
        run_op(32'd1234, 32'd5678, 6'd9, 2'b00, 1'b1, "mul");
        run_op(32'd100, 32'd7, 6'd10, 2'b00, 1'b0, "div");
        run_op(32'd100, 32'd7, 6'd11, 2'b00, 1'b0, "mod");
        run_op(32'h12345678, 32'd0, 6'd10, 2'b00, 1'b0, "div0");
        run_op(32'h12345678, 32'd0, 6'd11, 2'b00, 1'b0, "mod0");
        run_op(32'd9, 32'd9, 6'd2, 2'b10, 1'b0, "bne");
        run_op(32'd9, 32'd9, 6'd2, 2'b00, 1'b0, "beq");
        run_op(32'd1, 32'd40, 6'd7, 2'b00, 1'b0, "shl40");
        run_op(32'h80000000, 32'd31, 6'd8, 2'b00, 1'b0, "shr31");
        run_op(32'hFFFFFFFF, 32'd1, 6'd1, 2'b00, 1'b0, "addwrap");
        run_op(32'd3, 32'hABCD, 6'd9, 2'b01, 1'b0, "pass01");
        run_op(32'd7, 32'd7, 6'd63, 2'b00, 1'b0, "illegal");
        run_op(32'd9, 32'd9, 6'd1, 2'b00, 1'b0, "presetup");

        // Abort a multiply mid-flight with reset.
        data1 = 32'd77; data2 = 32'd99; operation = 6'd9; ALUOp = 2'b00; start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        repeat (9) begin @(posedge clock); #1; end
        reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        check("abort/outs", {61'd0, busy, done, zero}, 64'd0);
        check("abort/result", 64'(aluResult), 64'd0);
        ndone = 0;
        repeat (40) begin @(posedge clock); #1; if (done) ndone++; end
        check("abort/nodone", 64'(ndone), 64'd0);
        run_op(32'd3, 32'd4, 6'd1, 2'b00, 1'b0, "postabort");

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 40));
                1:       b = 32'd0;
                2:       b = a;
                default: b = $urandom;
            endcase
            run_op(a, b, 6'($urandom_range(0, 14)), 2'($urandom_range(0, 3)), (i % 7) == 0,
                   "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
